rgb_led_ctrl: RTL and testbench

//  CPU-mapped RGB LED controller on the 6502 peripheral bus, replacing direct gpio_o[5:3] LED drive.

---
 rtl/rgb_led_pkg.sv | 27 ++
 rtl/pwm_chan.sv | 41 ++++
 rtl/rgb_led_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rgb_led_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared register map, mode encodings and breathe states for rgb_led_ctrl
package rgb_led_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PRESC  = 3'd1;
  localparam logic [2:0] ADDR_DUTY_R = 3'd2;
  localparam logic [2:0] ADDR_DUTY_G = 3'd3;
  localparam logic [2:0] ADDR_DUTY_B = 3'd4;
  localparam logic [2:0] ADDR_BRATE  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_LEVEL  = 3'd7;

  localparam logic [7:0] BRATE_RST = 8'h10;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_DIRECT  = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } breathe_st_e;

endpackage

// File: rtl/pwm_chan.sv
// rtl/pwm_chan.sv - one LED channel: duty shadow, breathe scaling and PWM compare
module pwm_chan
  import rgb_led_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_duty_nxt,
  input  logic [7:0] i_duty,
  input  mode_e      i_mode,
  input  logic [7:0] i_level,
  input  logic [7:0] i_pwm_cnt,
  output logic       o_on
);

  logic [7:0] r_shadow;
  logic [7:0] w_scaled;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= i_duty_nxt;
    end
  end

  // Upper byte of the 16-bit duty x level product
  assign w_scaled = 8'(({8'd0, r_shadow} * {8'd0, i_level}) >> 8);

  always_comb begin
    o_on = 1'b0;
    case (i_mode)
      MODE_OFF:     o_on = 1'b0;
      MODE_DIRECT:  o_on = (i_duty != 8'd0);
      MODE_PWM:     o_on = (i_pwm_cnt < r_shadow);
      MODE_BREATHE: o_on = (i_pwm_cnt < w_scaled);
      default:      o_on = 1'b0;
    endcase
  end

endmodule

// File: rtl/rgb_led_ctrl.sv
// rtl/rgb_led_ctrl.sv - CPU-mapped RGB LED controller: bus registers, prescaler, PWM counter, breathe FSM
module rgb_led_ctrl
  import rgb_led_pkg::*;
#(
  parameter bit         LED_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] PRESC_RST      = 8'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] led
);

  mode_e       r_mode;
  logic [7:0]  r_presc;
  logic [7:0]  r_duty_r;
  logic [7:0]  r_duty_g;
  logic [7:0]  r_duty_b;
  logic [7:0]  r_brate;
  logic [7:0]  r_presc_cnt;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_step_cnt;
  logic [7:0]  r_level;
  logic [7:0]  w_level_nxt;
  breathe_st_e r_state;
  breathe_st_e w_state_nxt;
  logic        r_wrap_sticky;
  logic [2:0]  r_led;
  logic [2:0]  w_on;
  logic        w_wr;
  logic        w_rd;
  logic        w_mode_chg;
  logic        w_tick;
  logic        w_wrap;
  logic        w_step;
  logic        w_load;
  logic [7:0]  w_duty_nxt_r;
  logic [7:0]  w_duty_nxt_g;
  logic [7:0]  w_duty_nxt_b;

  assign w_wr       = cs & we;
  assign w_rd       = cs & ~we;
  assign w_mode_chg = w_wr && (addr == ADDR_CTRL) && (mode_e'(din[1:0]) != r_mode);
  assign w_tick     = (r_presc_cnt == r_presc);
  assign w_wrap     = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_step     = w_wrap && (r_mode == MODE_BREATHE) && (r_step_cnt == r_brate);
  assign w_load     = w_wrap | w_mode_chg;

  // A DUTY write landing on the wrap edge must reach the shadow directly
  assign w_duty_nxt_r = (w_wr && addr == ADDR_DUTY_R) ? din : r_duty_r;
  assign w_duty_nxt_g = (w_wr && addr == ADDR_DUTY_G) ? din : r_duty_g;
  assign w_duty_nxt_b = (w_wr && addr == ADDR_DUTY_B) ? din : r_duty_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= MODE_OFF;
      r_presc  <= PRESC_RST;
      r_duty_r <= '0;
      r_duty_g <= '0;
      r_duty_b <= '0;
      r_brate  <= BRATE_RST;
    end else if (w_wr) begin
      case (addr)
        ADDR_CTRL:   r_mode   <= mode_e'(din[1:0]);
        ADDR_PRESC:  r_presc  <= din;
        ADDR_DUTY_R: r_duty_r <= din;
        ADDR_DUTY_G: r_duty_g <= din;
        ADDR_DUTY_B: r_duty_b <= din;
        ADDR_BRATE:  r_brate  <= din;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_step_cnt  <= '0;
    end else if (w_mode_chg) begin
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_step_cnt  <= '0;
    end else begin
      r_presc_cnt <= w_tick ? 8'd0 : r_presc_cnt + 8'd1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      if (w_wrap && r_mode == MODE_BREATHE) begin
        r_step_cnt <= w_step ? 8'd0 : r_step_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_UP;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Direction flips on the step that reaches an extreme, so each extreme dwells one interval
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (w_mode_chg) begin
      w_state_nxt = ST_UP;
      w_level_nxt = '0;
    end else if (w_step) begin
      case (r_state)
        ST_UP: begin
          if (r_level != 8'hFF) w_level_nxt = r_level + 8'd1;
          if (r_level >= 8'hFE) w_state_nxt = ST_DOWN;
        end
        ST_DOWN: begin
          if (r_level != 8'h00) w_level_nxt = r_level - 8'd1;
          if (r_level <= 8'h01) w_state_nxt = ST_UP;
        end
        default: w_state_nxt = ST_UP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap_sticky <= 1'b0;
    end else if (w_wrap) begin
      r_wrap_sticky <= 1'b1;
    end else if (w_rd && addr == ADDR_STATUS) begin
      r_wrap_sticky <= 1'b0;
    end
  end

  pwm_chan u_chan_r (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_duty_nxt (w_duty_nxt_r),
    .i_duty     (r_duty_r),
    .i_mode     (r_mode),
    .i_level    (r_level),
    .i_pwm_cnt  (r_pwm_cnt),
    .o_on       (w_on[2])
  );

  pwm_chan u_chan_g (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_duty_nxt (w_duty_nxt_g),
    .i_duty     (r_duty_g),
    .i_mode     (r_mode),
    .i_level    (r_level),
    .i_pwm_cnt  (r_pwm_cnt),
    .o_on       (w_on[1])
  );

  pwm_chan u_chan_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_duty_nxt (w_duty_nxt_b),
    .i_duty     (r_duty_b),
    .i_mode     (r_mode),
    .i_level    (r_level),
    .i_pwm_cnt  (r_pwm_cnt),
    .o_on       (w_on[0])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= {3{LED_ACTIVE_LOW}};
    end else begin
      r_led <= w_on ^ {3{LED_ACTIVE_LOW}};
    end
  end

  assign led = r_led;

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = {6'd0, r_mode};
      ADDR_PRESC:  dout = r_presc;
      ADDR_DUTY_R: dout = r_duty_r;
      ADDR_DUTY_G: dout = r_duty_g;
      ADDR_DUTY_B: dout = r_duty_b;
      ADDR_BRATE:  dout = r_brate;
      ADDR_STATUS: dout = {6'd0, r_wrap_sticky, r_state};
      ADDR_LEVEL:  dout = r_level;
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// tb/tb_rgb_led_ctrl.sv - self-checking bench for rgb_led_ctrl
module tb_rgb_led_ctrl;
  import rgb_led_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic [2:0] led;

  int n_checks = 0;
  int n_errors = 0;
  int cur_mode = 0;

  typedef struct packed {
    logic       wr;
    logic [2:0] a;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [17];
  logic [7:0] rst_val [8];

  rgb_led_ctrl #(.LED_ACTIVE_LOW(1'b1), .PRESC_RST(8'd3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; we = 1'b0;
    if (a == ADDR_CTRL) cur_mode = int'(d[1:0]);
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    d = dout;
    cs = 1'b0;
  endtask

  task automatic read_clr(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    d = dout;
    step();
    cs = 1'b0;
  endtask

  // Triangle 0..255..0 indexed by number of breathe steps taken
  function automatic int tri_level(input int s);
    int l;
    l = s % 510;
    return (l <= 255) ? l : 510 - l;
  endfunction

  function automatic int steps_after(input int n, input int p, input int b);
    return (n / (256 * (p + 1))) / (b + 1);
  endfunction

  // Expected pin state given n clock edges since the restarting CTRL write
  function automatic logic [2:0] model_led(input int n, input int m, input int p, input int b,
                                           input int dr, input int dg, input int db);
    int pc, lvl, eff;
    int d [3];
    logic [2:0] on;
    d[0] = dr; d[1] = dg; d[2] = db;
    pc  = (n / (p + 1)) % 256;
    lvl = tri_level(steps_after(n, p, b));
    for (int i = 0; i < 3; i++) begin
      case (m)
        1:       on[2-i] = (d[i] != 0);
        2:       on[2-i] = (pc < d[i]);
        3: begin
          eff = (d[i] * lvl) / 256;
          on[2-i] = (pc < eff);
        end
        default: on[2-i] = 1'b0;
      endcase
    end
    return on ^ 3'b111;
  endfunction

  initial begin
    logic [7:0] rd;
    int cnt0, cnt1, cnt2, gall;

    rst_val = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 3'(i), 8'h00, rst_val[i]};
    vecs[8]  = '{1'b1, ADDR_CTRL,   8'hFE, 8'h02};
    vecs[9]  = '{1'b1, ADDR_PRESC,  8'h5A, 8'h5A};
    vecs[10] = '{1'b1, ADDR_DUTY_R, 8'hA5, 8'hA5};
    vecs[11] = '{1'b1, ADDR_DUTY_G, 8'h01, 8'h01};
    vecs[12] = '{1'b1, ADDR_DUTY_B, 8'hFF, 8'hFF};
    vecs[13] = '{1'b1, ADDR_BRATE,  8'h00, 8'h00};
    vecs[14] = '{1'b1, ADDR_STATUS, 8'hFF, 8'h00};
    vecs[15] = '{1'b1, ADDR_LEVEL,  8'h33, 8'h00};
    vecs[16] = '{1'b1, ADDR_CTRL,   8'h00, 8'h00};

    step(); step(); step();
    check("reset led", led, 3'b111);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].data);
      peek(vecs[i].a, rd);
      check($sformatf("reg vec%0d addr%0d", i, vecs[i].a), rd, vecs[i].exp);
    end

    // PWM: R duty 64 at full rate
    bus_write(ADDR_PRESC, 8'd0);
    bus_write(ADDR_DUTY_R, 8'd64);
    bus_write(ADDR_DUTY_G, 8'd0);
    bus_write(ADDR_DUTY_B, 8'd0);
    bus_write(ADDR_CTRL, 8'd2);
    cnt0 = 0; gall = 1;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (led[2] == 1'b0) cnt0++;
      if (led[1:0] != 2'b11) gall = 0;
    end
    check("pwm R on count", cnt0, 64);
    check("pwm G B dark", gall, 1);
    read_clr(ADDR_STATUS, rd);
    check("status wrap sticky", rd, 8'h02);
    peek(ADDR_STATUS, rd);
    check("status sticky cleared", rd, 8'h00);

    // Glitch-free shadowing, including a write landing on the wrap edge
    bus_write(ADDR_DUTY_R, 8'd0);
    bus_write(ADDR_DUTY_G, 8'd200);
    bus_write(ADDR_CTRL, 8'd0);
    bus_write(ADDR_CTRL, 8'd2);
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int k = 1; k <= 768; k++) begin
      if (k == 50)  begin cs = 1'b1; we = 1'b1; addr = ADDR_DUTY_G; din = 8'd10;  end
      if (k == 512) begin cs = 1'b1; we = 1'b1; addr = ADDR_DUTY_G; din = 8'd100; end
      step();
      cs = 1'b0; we = 1'b0;
      if (led[1] == 1'b0) begin
        if (k <= 256) cnt0++;
        else if (k <= 512) cnt1++;
        else cnt2++;
      end
    end
    check("glitch period0 G", cnt0, 200);
    check("glitch period1 G", cnt1, 10);
    check("wrap-edge write period2 G", cnt2, 100);

    // Direct mode
    bus_write(ADDR_DUTY_G, 8'd0);
    bus_write(ADDR_DUTY_B, 8'd1);
    bus_write(ADDR_CTRL, 8'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("direct B on %0d", k), led, 3'b110);
    end
    bus_write(ADDR_DUTY_B, 8'd0);
    step();
    check("direct B off", led, 3'b111);

    // Randomised segments against the arithmetic model
    for (int seg = 0; seg < 5; seg++) begin
      int m, p, b, s;
      int d [3];
      m = int'($urandom_range(0, 3));
      p = int'($urandom_range(0, 1));
      b = int'($urandom_range(0, 2));
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 3))
          0:       d[i] = 0;
          1:       d[i] = 255;
          default: d[i] = int'($urandom_range(0, 255));
        endcase
      end
      bus_write(ADDR_PRESC, 8'(p));
      bus_write(ADDR_BRATE, 8'(b));
      bus_write(ADDR_DUTY_R, 8'(d[0]));
      bus_write(ADDR_DUTY_G, 8'(d[1]));
      bus_write(ADDR_DUTY_B, 8'(d[2]));
      if (m == cur_mode) bus_write(ADDR_CTRL, 8'(m ^ 1));
      bus_write(ADDR_CTRL, {6'($urandom), 2'(m)});
      for (int k = 1; k <= 1500; k++) begin
        step();
        check($sformatf("rand seg%0d mode%0d k%0d led", seg, m, k), led,
              model_led(k - 1, m, p, b, d[0], d[1], d[2]));
      end
      if (m == 3) begin
        s = steps_after(1500, p, b);
        peek(ADDR_LEVEL, rd);
        check($sformatf("rand seg%0d level", seg), rd, tri_level(s));
        peek(ADDR_STATUS, rd);
        check($sformatf("rand seg%0d dir", seg), rd[0], ((s % 510) >= 255) ? 1 : 0);
      end
    end

    // Reset mid-PWM
    bus_write(ADDR_DUTY_R, 8'd255);
    if (cur_mode == 2) bus_write(ADDR_CTRL, 8'd0);
    bus_write(ADDR_CTRL, 8'd2);
    repeat (100) step();
    check("pre-reset R on", led[2], 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset led", led, 3'b111);
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), rd);
      check($sformatf("in-reset read addr%0d", i), rd, rst_val[i]);
    end
    step(); step();
    check("held reset led", led, 3'b111);
    reset_n = 1'b1;
    cur_mode = 0;
    step();
    check("post-reset led", led, 3'b111);

    // Breathe: full ramp up to 255, then two steps down
    bus_write(ADDR_PRESC, 8'd0);
    bus_write(ADDR_BRATE, 8'd0);
    bus_write(ADDR_DUTY_R, 8'd255);
    bus_write(ADDR_DUTY_G, 8'd255);
    bus_write(ADDR_DUTY_B, 8'd255);
    bus_write(ADDR_CTRL, 8'd3);
    for (int j = 1; j <= 255; j++) begin
      repeat (256) step();
      peek(ADDR_LEVEL, rd);
      check($sformatf("breathe level j%0d", j), rd, j);
      peek(ADDR_STATUS, rd);
      check($sformatf("breathe dir j%0d", j), rd[0], (j == 255) ? 1 : 0);
    end
    cnt0 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (led[2] == 1'b0) cnt0++;
    end
    check("breathe R on at level 255", cnt0, 254);
    peek(ADDR_LEVEL, rd);
    check("breathe down 254", rd, 254);
    peek(ADDR_STATUS, rd);
    check("breathe dir down", rd[0], 1'b1);
    repeat (256) step();
    peek(ADDR_LEVEL, rd);
    check("breathe down 253", rd, 253);

    // Mode switch mid-breathe restarts the sequencer
    bus_write(ADDR_CTRL, 8'd2);
    peek(ADDR_LEVEL, rd);
    check("switch pwm level", rd, 0);
    peek(ADDR_STATUS, rd);
    check("switch pwm dir", rd[0], 1'b0);
    bus_write(ADDR_CTRL, 8'd3);
    peek(ADDR_LEVEL, rd);
    check("back breathe level", rd, 0);
    repeat (255) step();
    peek(ADDR_LEVEL, rd);
    check("restart level before wrap", rd, 0);
    step();
    peek(ADDR_LEVEL, rd);
    check("restart level after wrap", rd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
